// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared widths, step count and state type for the multi-cycle arithmetic unit
package mul_seq_pkg;

  // Operand width shared by the multiplier and divider datapaths.
  localparam int MUL_W = 32;

  // One shift-add iteration per multiplier bit.
  localparam int MUL_STEPS = 32;

  // Iteration counter width; wide enough to index every step.
  localparam int CNT_W = $clog2(MUL_STEPS);

  // Counter value seen on the edge that performs the final iteration.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

  // Control state: IDLE holds results, RUN iterates.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mul_state_t;

  // The product is negative only for signed operations with operands of opposite sign.
  function automatic logic result_negative(input logic is_signed,
                                           input logic a_msb,
                                           input logic b_msb);
    return is_signed & (a_msb ^ b_msb);
  endfunction

endpackage

// File: rtl/mul_seq_cond_neg.sv
// rtl/mul_seq_cond_neg.sv - width-parameterised conditional two's-complement negation
module cond_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         en,
  output logic [W-1:0] y
);

  // Subtracting from zero gives the two's complement; -0 naturally stays 0,
  // and the most negative value maps onto itself, which read as unsigned is
  // exactly its magnitude.
  assign y = en ? (W'(0) - x) : x;

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential 32x32->64 signed/unsigned shift-add multiplier with start/busy handshake
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  input  logic             sign,
  input  logic             start,
  output logic [MUL_W-1:0] hi,
  output logic [MUL_W-1:0] lo,
  output logic             busy,
  output logic             done
);

  mul_state_t           state;
  logic [CNT_W-1:0]     count;
  logic                 neg;
  logic [MUL_W-1:0]     ma;
  logic [MUL_W:0]       acc;
  logic [MUL_W-1:0]     mplr;
  logic [2*MUL_W-1:0]   result;
  logic                 done_q;

  // Operand magnitudes; only used on a start edge.
  logic [MUL_W-1:0]     a_mag;
  logic [MUL_W-1:0]     b_mag;

  // Next-iteration datapath values.
  logic [MUL_W:0]       sum;
  logic [MUL_W:0]       acc_next;
  logic [MUL_W-1:0]     mplr_next;
  logic [2*MUL_W-1:0]   prod_mag;
  logic [2*MUL_W-1:0]   prod_signed;

  cond_neg #(.W(MUL_W)) u_neg_a (
    .x  (a),
    .en (sign & a[MUL_W-1]),
    .y  (a_mag)
  );

  cond_neg #(.W(MUL_W)) u_neg_b (
    .x  (b),
    .en (sign & b[MUL_W-1]),
    .y  (b_mag)
  );

  // One radix-2 step: conditionally add the multiplicand, then shift the
  // {acc, mplr} pair right so the next multiplier bit lands in mplr[0].
  always_comb begin
    sum       = acc + (mplr[0] ? {1'b0, ma} : '0);
    acc_next  = {1'b0, sum[MUL_W:1]};
    mplr_next = {sum[0], mplr[MUL_W-1:1]};
    // After the final shift the product fits in 64 bits, so acc[32] is zero.
    prod_mag  = {acc_next[MUL_W-1:0], mplr_next};
  end

  cond_neg #(.W(2*MUL_W)) u_neg_p (
    .x  (prod_mag),
    .en (neg),
    .y  (prod_signed)
  );

  // Control and datapath state; start overrides everything except reset,
  // so an in-flight or just-finishing operation is silently abandoned.
  always_ff @(negedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      count  <= '0;
      neg    <= 1'b0;
      ma     <= '0;
      acc    <= '0;
      mplr   <= '0;
      result <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      state  <= S_RUN;
      count  <= '0;
      neg    <= result_negative(sign, a[MUL_W-1], b[MUL_W-1]);
      ma     <= a_mag;
      acc    <= '0;
      mplr   <= b_mag;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          acc   <= acc_next;
          mplr  <= mplr_next;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            state  <= S_IDLE;
            result <= prod_signed;
            done_q <= 1'b1;
          end else begin
            done_q <= 1'b0;
          end
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = done_q;
  assign hi   = result[2*MUL_W-1:MUL_W];
  assign lo   = result[MUL_W-1:0];

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - self-checking bench for mul_seq
module tb_mul_seq;

  logic        clock;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        sign;
  logic        start;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp = 64'h0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  mul_seq dut (
    .clock (clock),
    .reset (reset),
    .a     (a),
    .b     (b),
    .sign  (sign),
    .start (start),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic signed [63:0] sp;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      sp = sx * sy;
      return sp;
    end
    return {32'h0, x} * {32'h0, y};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
    end
  endtask

  // Outputs change on the falling edge; compare on the rising edge.
  always @(posedge clock) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", {hi, lo}, 64'hx);
      end else begin
        last_exp = exp_q.pop_front();
        check("product", {hi, lo}, last_exp);
      end
    end
  end

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
    @(posedge clock);
    a = ta; b = tb_v; sign = ts; start = 1'b1;
    @(posedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (busy === 1'b1) cyc++;
      if (done === 1'b1) got = 1'b1;
      else @(posedge clock);
    end
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                        input logic [63:0] texp);
    int cyc;
    bit got;
    exp_q.push_back(texp);
    start_op(ta, tb_v, ts);
    wait_done(cyc, got);
    check("done_seen", 64'(got), 64'd1);
    check("busy_cycles", 64'(cyc), 64'd32);
    @(posedge clock);
    check("done_one_cycle", {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int cyc;
    bit got;
    int d0;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; sign = 1'b0;
    repeat (2) @(posedge clock);
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    check("idle_hilo", {hi, lo}, 64'h0);
    check("idle_busy_done", {62'd0, busy, done}, 64'd0);

    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000007, 1'b1, 64'hFFFFFFFF_FFFFFFF9});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000007, 1'b0, 64'h00000006_FFFFFFF9});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000});
    vecs.push_back('{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000});
    vecs.push_back('{32'h00000000, 32'h80000000, 1'b1, 64'h0});
    vecs.push_back('{32'h00000003, 32'hFFFFFFFB, 1'b1, 64'hFFFFFFFF_FFFFFFF1});
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.a = $urandom; v.b = $urandom; v.sign = 1'(i & 1);
      v.exp = model(v.a, v.b, v.sign);
      vecs.push_back(v);
    end

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].sign, vecs[i].exp);

    // Abort: restart while busy, then scramble inputs mid-run.
    d0 = done_cnt;
    start_op(32'd3, 32'd5, 1'b0);
    repeat (9) @(posedge clock);
    exp_q.push_back(64'd42);
    start_op(32'd6, 32'd7, 1'b0);
    a = $urandom; b = $urandom; sign = 1'b1;
    wait_done(cyc, got);
    check("abort_done_seen", 64'(got), 64'd1);
    check("abort_latency", 64'(cyc), 64'd32);
    @(posedge clock);
    check("abort_single_done", 64'(done_cnt - d0), 64'd1);

    // Start on the completion edge: start wins, result register untouched.
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    repeat (31) @(posedge clock);
    a = 32'd4; b = 32'd5; sign = 1'b0; start = 1'b1;
    exp_q.push_back(64'd20);
    @(posedge clock);
    start = 1'b0;
    check("collide_no_done", 64'(done), 64'd0);
    check("collide_busy", 64'(busy), 64'd1);
    check("collide_hold", {hi, lo}, 64'd42);
    wait_done(cyc, got);
    check("collide_done_seen", 64'(got), 64'd1);
    check("collide_latency", 64'(cyc), 64'd32);
    @(posedge clock);

    // Reset mid-run.
    start_op(32'd9, 32'd9, 1'b0);
    repeat (14) @(posedge clock);
    reset = 1'b1;
    @(posedge clock);
    check("midreset_hilo", {hi, lo}, 64'h0);
    check("midreset_busy_done", {62'd0, busy, done}, 64'd0);
    reset = 1'b0;
    run_op(32'd2, 32'd3, 1'b0, 64'd6);

    repeat (3) @(posedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
